// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: per-sprite attribute
// bundle, default key/background colors and the pipeline latency helper.
package sprite_pkg;

   localparam logic [23:0] KEY_COLOR_DEF = 24'hFF0000;
   localparam logic [23:0] BG_COLOR_DEF  = 24'hB7FE7B;
   localparam int          SPR_BASE_W    = 19;

   typedef struct packed {
      logic                  en;
      logic [9:0]            x;
      logic [9:0]            y;
      logic [2:0]            wlog2;
      logic [2:0]            hlog2;
      logic                  hflip;
      logic                  vflip;
      logic [SPR_BASE_W-1:0] base;
   } sprite_attr_t;

   // Pixel-in to color-out latency: address stage + ROM + select stage.
   function automatic int latency(input int rom_latency);
      return rom_latency + 2;
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Stage A for one sprite layer: registered hit test, flip and ROM address.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int ADDR_W = 19
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [9:0]        draw_x_i,
   input  logic [9:0]        draw_y_i,
   input  sprite_attr_t      attr_i,
   output logic              hit_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [10:0]       x_end, y_end;
   logic              hit_d, hit_q;
   logic [6:0]        lx, ly, w_m1, h_m1;
   logic [ADDR_W-1:0] base, offset, addr_d, addr_q;

   always_comb begin
      // 11-bit right/bottom edges so a sprite hanging past 1023 never wraps.
      x_end  = {1'b0, attr_i.x} + (11'd1 << attr_i.wlog2);
      y_end  = {1'b0, attr_i.y} + (11'd1 << attr_i.hlog2);
      hit_d  = attr_i.en
               && (draw_x_i >= attr_i.x) && ({1'b0, draw_x_i} < x_end)
               && (draw_y_i >= attr_i.y) && ({1'b0, draw_y_i} < y_end);
      w_m1   = 7'h7F >> (3'd7 - attr_i.wlog2);
      h_m1   = 7'h7F >> (3'd7 - attr_i.hlog2);
      // Local offsets are below 128 when hit, so 7-bit differences suffice.
      lx     = draw_x_i[6:0] - attr_i.x[6:0];
      ly     = draw_y_i[6:0] - attr_i.y[6:0];
      if (attr_i.hflip) lx = w_m1 - lx;
      if (attr_i.vflip) ly = h_m1 - ly;
      base   = ADDR_W'(attr_i.base);
      offset = (ADDR_W'(ly) << attr_i.wlog2) + ADDR_W'(lx);
      addr_d = hit_d ? base + offset : base;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_q  <= 1'b0;
         addr_q <= '0;
      end else begin
         hit_q  <= hit_d;
         addr_q <= addr_d;
      end
   end

   assign hit_o  = hit_q;
   assign addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite compositor: address generation per layer, ROM-aligned
// delay lines, priority color select and per-frame collision flags.
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int          NUM_SPRITES = 8,
   parameter int          ADDR_W      = 19,
   parameter int          ROM_LATENCY = 1,
   parameter logic [23:0] BG_COLOR    = BG_COLOR_DEF,
   parameter logic [23:0] KEY_COLOR   = KEY_COLOR_DEF
) (
   input  logic                                Clk,
   input  logic                                Reset,
   input  logic                                pix_valid,
   input  logic                                frame_start,
   input  logic [9:0]                          DrawX,
   input  logic [9:0]                          DrawY,
   input  logic [NUM_SPRITES-1:0]              spr_en,
   input  logic [NUM_SPRITES-1:0][9:0]         spr_x,
   input  logic [NUM_SPRITES-1:0][9:0]         spr_y,
   input  logic [NUM_SPRITES-1:0][2:0]         spr_wlog2,
   input  logic [NUM_SPRITES-1:0][2:0]         spr_hlog2,
   input  logic [NUM_SPRITES-1:0]              spr_hflip,
   input  logic [NUM_SPRITES-1:0]              spr_vflip,
   input  logic [NUM_SPRITES-1:0][ADDR_W-1:0]  spr_base,
   output logic [NUM_SPRITES-1:0][ADDR_W-1:0]  rom_addr,
   input  logic [NUM_SPRITES-1:0][23:0]        rom_data,
   output logic [7:0]                          VGA_R,
   output logic [7:0]                          VGA_G,
   output logic [7:0]                          VGA_B,
   output logic                                out_valid,
   output logic [NUM_SPRITES-1:0]              collide
);

   // The delay lines cover only the ROM share of the total latency.
   localparam int DL_DEPTH = latency(ROM_LATENCY) - 2;

   sprite_attr_t                             attr [NUM_SPRITES];
   logic [NUM_SPRITES-1:0]                   hit_a;
   logic                                     valid_a_q, fs_a_q;
   logic [DL_DEPTH-1:0][NUM_SPRITES-1:0]     hit_dl_q;
   logic [DL_DEPTH-1:0]                      valid_dl_q, fs_dl_q;
   logic [NUM_SPRITES-1:0]                   hit_b, opaque, coll_now;
   logic                                     valid_b, fs_b;
   logic [23:0]                              color_d, color_q;
   logic                                     out_valid_q;
   logic [NUM_SPRITES-1:0]                   acc_d, acc_q, collide_d, collide_q;

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         attr[i] = '{en: spr_en[i], x: spr_x[i], y: spr_y[i],
                     wlog2: spr_wlog2[i], hlog2: spr_hlog2[i],
                     hflip: spr_hflip[i], vflip: spr_vflip[i],
                     base: SPR_BASE_W'(spr_base[i])};
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_addr
      sprite_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
         .clk_i    (Clk),
         .rst_i    (Reset),
         .draw_x_i (DrawX),
         .draw_y_i (DrawY),
         .attr_i   (attr[g]),
         .hit_o    (hit_a[g]),
         .addr_o   (rom_addr[g])
      );
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         valid_a_q  <= 1'b0;
         fs_a_q     <= 1'b0;
         hit_dl_q   <= '0;
         valid_dl_q <= '0;
         fs_dl_q    <= '0;
      end else begin
         valid_a_q     <= pix_valid;
         fs_a_q        <= frame_start;
         hit_dl_q[0]   <= hit_a;
         valid_dl_q[0] <= valid_a_q;
         fs_dl_q[0]    <= fs_a_q;
         for (int k = 1; k < DL_DEPTH; k++) begin
            hit_dl_q[k]   <= hit_dl_q[k-1];
            valid_dl_q[k] <= valid_dl_q[k-1];
            fs_dl_q[k]    <= fs_dl_q[k-1];
         end
      end
   end

   assign hit_b   = hit_dl_q[DL_DEPTH-1];
   assign valid_b = valid_dl_q[DL_DEPTH-1];
   assign fs_b    = fs_dl_q[DL_DEPTH-1];

   always_comb begin
      color_d  = BG_COLOR;
      opaque   = '0;
      coll_now = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         opaque[i] = hit_b[i] && (rom_data[i] != KEY_COLOR);
      end
      // Walk from lowest priority upward so index 0 lands last and wins.
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (opaque[i]) color_d = rom_data[i];
      end
      if (!valid_b) color_d = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         coll_now[i] = valid_b && opaque[i]
                       && (|(opaque & ~(NUM_SPRITES'(1) << i)));
      end
      // The frame's first pixel seeds the fresh accumulator.
      acc_d     = fs_b ? coll_now : (acc_q | coll_now);
      collide_d = fs_b ? acc_q : collide_q;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         color_q     <= '0;
         out_valid_q <= 1'b0;
         acc_q       <= '0;
         collide_q   <= '0;
      end else begin
         color_q     <= color_d;
         out_valid_q <= valid_b;
         acc_q       <= acc_d;
         collide_q   <= collide_d;
      end
   end

   assign VGA_R     = color_q[23:16];
   assign VGA_G     = color_q[15:8];
   assign VGA_B     = color_q[7:0];
   assign out_valid = out_valid_q;
   assign collide   = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: behavioral ROM, reference pixel model feeding
// an expected-output queue, directed corner cases and a random phase.
module tb_sprite_compositor;

   localparam int          N   = 8;
   localparam int          AW  = 19;
   localparam int          W   = 33;
   localparam logic [23:0] KEY = 24'hFF0000;
   localparam logic [23:0] BG  = 24'hB7FE7B;

   logic                    Clk, Reset, pix_valid, frame_start;
   logic [9:0]              DrawX, DrawY;
   logic [N-1:0]            spr_en, spr_hflip, spr_vflip;
   logic [N-1:0][9:0]       spr_x, spr_y;
   logic [N-1:0][2:0]       spr_wlog2, spr_hlog2;
   logic [N-1:0][AW-1:0]    spr_base, rom_addr;
   logic [N-1:0][23:0]      rom_data;
   logic [7:0]              VGA_R, VGA_G, VGA_B;
   logic                    out_valid;
   logic [N-1:0]            collide;

   logic [N-1:0]            ovr_en;
   logic [23:0]             ovr_val [N];
   logic [W-1:0]            exp_q [$];
   logic [N-1:0]            m_acc, m_col;
   int                      checks = 0;
   int                      errors = 0;

   sprite_compositor dut (
      .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .frame_start(frame_start),
      .DrawX(DrawX), .DrawY(DrawY), .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y),
      .spr_wlog2(spr_wlog2), .spr_hlog2(spr_hlog2), .spr_hflip(spr_hflip),
      .spr_vflip(spr_vflip), .spr_base(spr_base), .rom_addr(rom_addr),
      .rom_data(rom_data), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .out_valid(out_valid), .collide(collide)
   );

   // ---------------- clock / reset ----------------
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Texel source: a fixed color per layer, or a pattern keyed on every 8th word.
   function automatic logic [23:0] tex(input int i, input logic [AW-1:0] a);
      if (ovr_en[i]) return ovr_val[i];
      if (a[2:0] == 3'd0) return KEY;
      return {4'(i), 1'b0, a};
   endfunction

   // One-cycle ROM
   always @(posedge Clk) begin
      for (int i = 0; i < N; i++) rom_data[i] <= tex(i, rom_addr[i]);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model(input logic v, input logic fs, input logic [9:0] px, input logic [9:0] py,
                        output logic [W-1:0] word, output logic [N-1:0][AW-1:0] ea);
      logic [N-1:0] op, c;
      logic [23:0]  col;
      int           sel, nop;
      op = '0; c = '0; sel = -1; nop = 0;
      for (int i = 0; i < N; i++) begin
         int w, h, sx, sy, lx, ly, a;
         logic hit;
         w  = 1 << spr_wlog2[i];
         h  = 1 << spr_hlog2[i];
         sx = int'(spr_x[i]);
         sy = int'(spr_y[i]);
         hit = spr_en[i] && (int'(px) >= sx) && (int'(px) < sx + w)
               && (int'(py) >= sy) && (int'(py) < sy + h);
         lx = int'(px) - sx;
         ly = int'(py) - sy;
         if (spr_hflip[i]) lx = w - 1 - lx;
         if (spr_vflip[i]) ly = h - 1 - ly;
         a = (int'(spr_base[i]) + ly * w + lx) % (1 << AW);
         ea[i] = hit ? AW'(a) : spr_base[i];
         op[i] = hit && (tex(i, ea[i]) != KEY);
         if (op[i]) begin
            nop++;
            if (sel < 0) sel = i;
         end
      end
      col = (sel >= 0) ? tex(sel, ea[sel]) : BG;
      if (!v) col = 24'h0;
      for (int i = 0; i < N; i++) c[i] = v && op[i] && (nop > 1);
      if (fs) begin
         m_col = m_acc;
         m_acc = c;
      end else begin
         m_acc = m_acc | c;
      end
      word = {v, col, m_col};
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic v, input logic fs, input logic [9:0] px, input logic [9:0] py);
      logic [W-1:0]          e;
      logic [N-1:0][AW-1:0]  ea;
      pix_valid   = v;
      frame_start = fs;
      DrawX       = px;
      DrawY       = py;
      model(v, fs, px, py, e, ea);
      exp_q.push_back(e);
      @(posedge Clk); #1;
      for (int i = 0; i < N; i++)
         check($sformatf("rom_addr%0d", i), 64'(rom_addr[i]), 64'(ea[i]));
      if (exp_q.size() >= 3)
         check("pixel_out", 64'({out_valid, VGA_R, VGA_G, VGA_B, collide}), 64'(exp_q.pop_front()));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0;
      @(posedge Clk); #1;
      check("rst_rgb", 64'({VGA_R, VGA_G, VGA_B}), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_collide", 64'(collide), 64'(0));
      check("rst_rom_addr", 64'(rom_addr), 64'(0));
      Reset = 1'b0;
      exp_q.delete();
      m_acc = '0;
      m_col = '0;
   endtask

   task automatic clear_sprites();
      spr_en = '0; spr_hflip = '0; spr_vflip = '0;
      spr_x = '0; spr_y = '0; spr_wlog2 = '0; spr_hlog2 = '0; spr_base = '0;
      ovr_en = '0;
   endtask

   task automatic set_sprite(input int i, input int x, input int y, input int wl, input int hl,
                             input int base);
      spr_en[i] = 1'b1;
      spr_x[i] = 10'(x); spr_y[i] = 10'(y);
      spr_wlog2[i] = 3'(wl); spr_hlog2[i] = 3'(hl);
      spr_base[i] = AW'(base);
      spr_hflip[i] = 1'b0; spr_vflip[i] = 1'b0;
   endtask

   task automatic random_sprites();
      for (int i = 0; i < N; i++) begin
         spr_en[i]    = ($urandom_range(0, 3) != 0);
         spr_x[i]     = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(980, 1023))
                                                    : 10'($urandom_range(0, 250));
         spr_y[i]     = 10'($urandom_range(0, 250));
         spr_wlog2[i] = 3'($urandom_range(0, 7));
         spr_hlog2[i] = 3'($urandom_range(0, 7));
         spr_hflip[i] = 1'($urandom_range(0, 1));
         spr_vflip[i] = 1'($urandom_range(0, 1));
         spr_base[i]  = AW'($urandom_range(0, (1 << AW) - 1));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < N; i++) ovr_val[i] = 24'h0;
      clear_sprites();
      Reset = 1'b1; pix_valid = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
      m_acc = '0; m_col = '0;
      @(posedge Clk); #1;
      do_reset();

      // Single sprite, plain and flipped addressing
      set_sprite(0, 100, 50, 5, 5, 0);
      ovr_en[0] = 1'b1; ovr_val[0] = 24'h123456;
      cycle(1, 0, 10'd110, 10'd60);
      check("addr_plain", 64'(rom_addr[0]), 64'd330);
      idle(2);
      check("rgb_single", 64'({VGA_R, VGA_G, VGA_B}), 64'h123456);
      check("valid_single", 64'(out_valid), 64'd1);
      spr_hflip[0] = 1'b1; spr_vflip[0] = 1'b1;
      cycle(1, 0, 10'd110, 10'd60);
      check("addr_flip", 64'(rom_addr[0]), 64'd693);
      idle(2);
      spr_hflip[0] = 1'b0; spr_vflip[0] = 1'b0;

      // Priority between overlapping sprites 0 and 3
      set_sprite(3, 100, 50, 5, 5, 1000);
      ovr_en[3] = 1'b1; ovr_val[3] = 24'h00FF00; ovr_val[0] = KEY;
      cycle(1, 0, 10'd110, 10'd60); idle(2);
      check("rgb_key_passthru", 64'({VGA_R, VGA_G, VGA_B}), 64'h00FF00);
      ovr_val[0] = 24'hAA5511;
      cycle(1, 0, 10'd110, 10'd60); idle(2);
      check("rgb_priority", 64'({VGA_R, VGA_G, VGA_B}), 64'hAA5511);

      // Background cases and invalid pixel
      cycle(1, 0, 10'd600, 10'd400); idle(2);
      check("rgb_nohit", 64'({VGA_R, VGA_G, VGA_B}), 64'hB7FE7B);
      ovr_val[0] = KEY; ovr_val[3] = KEY;
      cycle(1, 0, 10'd110, 10'd60); idle(2);
      check("rgb_allkey", 64'({VGA_R, VGA_G, VGA_B}), 64'hB7FE7B);
      cycle(0, 0, 10'd110, 10'd60); idle(2);
      check("rgb_invalid", 64'({VGA_R, VGA_G, VGA_B}), 64'h0);
      check("valid_invalid", 64'(out_valid), 64'd0);

      // Collision flags across three frames
      clear_sprites();
      set_sprite(1, 300, 300, 0, 0, 10); set_sprite(2, 300, 300, 0, 0, 20);
      ovr_en[1] = 1'b1; ovr_val[1] = 24'h111111;
      ovr_en[2] = 1'b1; ovr_val[2] = 24'h222222;
      cycle(1, 1, 10'd0, 10'd0);
      cycle(1, 0, 10'd300, 10'd300);
      idle(2);
      cycle(1, 1, 10'd0, 10'd0); idle(2);
      check("collide_frame1", 64'(collide), 64'h06);
      cycle(1, 1, 10'd0, 10'd0); idle(2);
      check("collide_frame2", 64'(collide), 64'h00);

      // Right-edge sprite must not wrap to column 0
      clear_sprites();
      set_sprite(0, 1010, 0, 5, 5, 77);
      cycle(1, 0, 10'd5, 10'd10);
      check("addr_nowrap", 64'(rom_addr[0]), 64'd77);
      cycle(1, 0, 10'd1020, 10'd10);
      check("addr_edge_hit", 64'(rom_addr[0]), 64'd407);
      idle(2);

      // Random sprites and pixels
      for (int n = 0; n < 1500; n++) begin
         if (n % 100 == 0) random_sprites();
         cycle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 63) == 0),
               10'($urandom_range(0, 300)), 10'($urandom_range(0, 300)));
      end

      // Reset with pixels in flight
      cycle(1, 0, 10'd120, 10'd120);
      cycle(1, 1, 10'd130, 10'd130);
      do_reset();
      for (int n = 0; n < 200; n++) begin
         cycle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 31) == 0),
               10'($urandom_range(0, 300)), 10'($urandom_range(0, 300)));
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
